// File: rtl/modbus_tx_sequencer.sv
// Modbus RTU frame transmit sequencer: frame buffer -> uart_tx, then T3.5 silence.
// Define MODBUS_TX_CRC_EN to append CRC-16/MODBUS (low byte first) to every frame.
module modbus_tx_sequencer #(
    parameter int unsigned CLKS_PER_BIT = 347,
    parameter int unsigned T35_BITS     = 39
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Start,
    input  logic [7:0] i_Len,
    output logic [7:0] o_Buf_Addr,
    input  logic [7:0] i_Buf_Data,
    output logic       o_Tx_DV,
    output logic [7:0] o_Tx_Byte,
    input  logic       i_Tx_Active,
    input  logic       i_Tx_Done,
    output logic       o_Busy,
    output logic       o_Done,
    output logic       o_Err
);

    localparam int unsigned SILENCE_CLKS = T35_BITS * CLKS_PER_BIT;
    localparam logic [23:0] SIL_LAST     = 24'(SILENCE_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_CRC_LO,
        S_CRC_HI,
        S_SILENCE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  byte_q, byte_d;
    logic        dv_q, dv_d;
    logic [23:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        quiet_q, quiet_d;
    logic        done_prev_q, done_prev_d;

    logic        done_edge;
    logic        last_byte;
    logic        len_bad;

`ifdef MODBUS_TX_CRC_EN
    typedef enum logic [1:0] {
        PH_DATA,
        PH_CRC_LO,
        PH_CRC_HI
    } phase_t;

    phase_t      phase_q, phase_d;
    logic [15:0] crc_q, crc_d;

    // Fold one byte into CRC-16/MODBUS, all eight bit-steps in one cycle.
    function automatic logic [15:0] crc_fold(
        input logic [15:0] crc,
        input logic [7:0]  data
    );
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    assign len_bad = (i_Len == 8'd0) || (i_Len > 8'd254);
`else
    assign len_bad = (i_Len == 8'd0);
`endif

    assign done_edge = i_Tx_Done & ~done_prev_q;
    assign last_byte = (addr_q == len_q - 8'd1);

    assign o_Buf_Addr = addr_q;
    assign o_Tx_DV    = dv_q;
    assign o_Tx_Byte  = byte_q;
    assign o_Err      = err_q;
    assign o_Busy     = (state_q != S_IDLE);
    assign o_Done     = (state_q == S_SILENCE) && (cnt_q == SIL_LAST) && !quiet_q;

    // Next-state and datapath updates for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        byte_d      = byte_q;
        dv_d        = dv_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        quiet_d     = quiet_q;
        done_prev_d = i_Tx_Done;
`ifdef MODBUS_TX_CRC_EN
        phase_d     = phase_q;
        crc_d       = crc_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (i_Start) begin
                    if (len_bad) begin
                        err_d = 1'b1;
                    end else begin
                        len_d   = i_Len;
                        addr_d  = 8'd0;
                        state_d = S_FETCH;
`ifdef MODBUS_TX_CRC_EN
                        crc_d   = 16'hFFFF;
                        phase_d = PH_DATA;
`endif
                    end
                end
            end

            S_FETCH: begin
                state_d = S_LOAD;
            end

            S_LOAD: begin
                byte_d  = i_Buf_Data;
                dv_d    = 1'b1;
                state_d = S_SEND;
`ifdef MODBUS_TX_CRC_EN
                crc_d   = crc_fold(crc_q, i_Buf_Data);
`endif
            end

            S_SEND: begin
                if (i_Tx_Active) begin
                    dv_d    = 1'b0;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (done_edge) begin
`ifdef MODBUS_TX_CRC_EN
                    unique case (phase_q)
                        PH_DATA: begin
                            if (last_byte) begin
                                phase_d = PH_CRC_LO;
                                state_d = S_CRC_LO;
                            end else begin
                                addr_d  = addr_q + 8'd1;
                                state_d = S_FETCH;
                            end
                        end
                        PH_CRC_LO: begin
                            phase_d = PH_CRC_HI;
                            state_d = S_CRC_HI;
                        end
                        default: begin
                            cnt_d   = '0;
                            state_d = S_SILENCE;
                        end
                    endcase
`else
                    if (last_byte) begin
                        cnt_d   = '0;
                        state_d = S_SILENCE;
                    end else begin
                        addr_d  = addr_q + 8'd1;
                        state_d = S_FETCH;
                    end
`endif
                end
            end

`ifdef MODBUS_TX_CRC_EN
            S_CRC_LO: begin
                byte_d  = crc_q[7:0];
                dv_d    = 1'b1;
                state_d = S_SEND;
            end

            S_CRC_HI: begin
                byte_d  = crc_q[15:8];
                dv_d    = 1'b1;
                state_d = S_SEND;
            end
`endif

            S_SILENCE: begin
                if (cnt_q == SIL_LAST) begin
                    cnt_d   = '0;
                    quiet_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end

            default: begin
                dv_d    = 1'b0;
                cnt_d   = '0;
                state_d = S_SILENCE;
            end
        endcase
    end

    // State and datapath registers; reset restarts the silence window quietly.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q     <= S_SILENCE;
            addr_q      <= 8'd0;
            len_q       <= 8'd0;
            byte_q      <= 8'd0;
            dv_q        <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            quiet_q     <= 1'b1;
            done_prev_q <= 1'b0;
`ifdef MODBUS_TX_CRC_EN
            phase_q     <= PH_DATA;
            crc_q       <= 16'hFFFF;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            byte_q      <= byte_d;
            dv_q        <= dv_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            quiet_q     <= quiet_d;
            done_prev_q <= done_prev_d;
`ifdef MODBUS_TX_CRC_EN
            phase_q     <= phase_d;
            crc_q       <= crc_d;
`endif
        end
    end

endmodule

// File: tb/tb_modbus_tx_sequencer.sv
// Bench for modbus_tx_sequencer with a behavioural uart_tx and line decoder.
// Frame-level reference model checked every cycle; honours MODBUS_TX_CRC_EN.
`timescale 1ns/1ps
module tb_modbus_tx_sequencer;

    localparam int CPB = 4;
    localparam int T35 = 39;
    localparam int SIL = CPB * T35;
`ifdef MODBUS_TX_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif
    localparam int EXTRA = CRC_ON ? 2 : 0;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic [7:0] len   = 8'd0;
    logic [7:0] buf_addr;
    logic [7:0] buf_rd;
    logic       dv;
    logic [7:0] txb;
    logic       busy;
    logic       done_o;
    logic       err_o;

    logic       u_active = 1'b0;
    logic       u_done   = 1'b0;
    logic       u_ser    = 1'b1;

    logic [7:0] buf_mem [256];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    modbus_tx_sequencer #(
        .CLKS_PER_BIT(CPB),
        .T35_BITS    (T35)
    ) dut (
        .i_Clock    (clk),
        .i_Reset    (rst),
        .i_Start    (start),
        .i_Len      (len),
        .o_Buf_Addr (buf_addr),
        .i_Buf_Data (buf_rd),
        .o_Tx_DV    (dv),
        .o_Tx_Byte  (txb),
        .i_Tx_Active(u_active),
        .i_Tx_Done  (u_done),
        .o_Busy     (busy),
        .o_Done     (done_o),
        .o_Err      (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h at %0t",
                      name, act, exp, $time);
    endtask

    function automatic logic [15:0] crc_of(input logic [7:0] q[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (q[i]) begin
            c = c ^ {8'h00, q[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    // Frame buffer with one cycle of read latency.
    always @(posedge clk) buf_rd <= buf_mem[buf_addr];

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural uart_tx: 10 bits of CPB clocks, Done high for 2 cycles, no reset.
    int         u_st = 0, u_cnt = 0, u_bit = 0;
    logic [9:0] u_frm = '0;
    logic [7:0] handed[$];
    int         n_handed = 0, start_cyc = 0, stop_cyc = 0;

    always @(posedge clk) begin
        case (u_st)
            0: begin
                u_done <= 1'b0;
                if (dv === 1'b1) begin
                    u_active  <= 1'b1;
                    u_frm     <= {1'b1, txb, 1'b0};
                    u_ser     <= 1'b0;
                    u_bit     <= 0;
                    u_cnt     <= 0;
                    u_st      <= 1;
                    handed.push_back(txb);
                    n_handed  <= n_handed + 1;
                    start_cyc <= cyc;
                end
            end
            1: begin
                if (u_cnt == CPB - 1) begin
                    u_cnt <= 0;
                    if (u_bit == 9) begin
                        u_active <= 1'b0;
                        u_done   <= 1'b1;
                        u_st     <= 2;
                        stop_cyc <= cyc;
                    end else begin
                        u_bit <= u_bit + 1;
                        u_ser <= u_frm[u_bit + 1];
                    end
                end else begin
                    u_cnt <= u_cnt + 1;
                end
            end
            default: begin
                u_done <= 1'b1;
                u_st   <= 0;
            end
        endcase
    end

    // Event counters and timestamps.
    int   n_done = 0, n_dv_cyc = 0, n_err = 0, t_done = 0, t_uedge = 0;
    logic u_done_prev = 1'b0;
    always @(negedge clk) begin
        if (done_o === 1'b1) begin
            n_done <= n_done + 1;
            t_done <= cyc;
        end
        if (dv === 1'b1) n_dv_cyc <= n_dv_cyc + 1;
        if (err_o === 1'b1) n_err <= n_err + 1;
        if (u_done && !u_done_prev) t_uedge <= cyc;
        u_done_prev <= u_done;
    end

    // Serial line decoder, mid-bit sampling.
    logic [7:0] rx_log[$];
    int         n_rx = 0;
    initial begin : decoder
        logic [7:0] b;
        logic [7:0] want;
        b = '0;
        forever begin
            @(negedge clk);
            if (u_ser === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = u_ser;
                end
                repeat (CPB) @(negedge clk);
                chk("stop_bit", u_ser, 1);
                rx_log.push_back(b);
                n_rx++;
                chk("wire_queue", handed.size() > 0, 1);
                if (handed.size() > 0) begin
                    want = handed.pop_front();
                    chk("wire_byte", b, want);
                end
            end
        end
    end

    // Frame-level reference model, compared every cycle once reset has been seen.
    int         m_on = 0, m_busy = 0, m_sil = 0, m_quiet = 0;
    int         m_fetch = 0, m_dv = 0, m_wait = 0, m_err = 0;
    int         m_idx = 0, m_len = 0;
    logic [7:0] m_addr = '0;
    logic [7:0] m_q[$];
    logic       m_prev = 1'b0;

    initial begin : model
        logic [15:0] c;
        forever begin
            @(negedge clk);
            if (m_on != 0) begin
                chk("busy", busy, m_busy);
                chk("tx_dv", dv, m_dv);
                chk("err", err_o, m_err);
                chk("done", done_o, (m_busy != 0) && (m_sil == 1) && (m_quiet == 0));
                chk("buf_addr", buf_addr, m_addr);
                if (m_dv != 0 || m_wait != 0) chk("tx_byte", txb, m_q[m_idx]);
            end
            if (rst === 1'b1) begin
                m_on = 1; m_busy = 1; m_sil = SIL; m_quiet = 1;
                m_fetch = 0; m_dv = 0; m_wait = 0; m_err = 0;
                m_addr = '0; m_q.delete();
            end else if (m_on != 0) begin
                m_err = 0;
                if (m_busy == 0) begin
                    if (start) begin
                        if (len == 0 || (CRC_ON && len > 254)) begin
                            m_err = 1;
                        end else begin
                            m_q.delete();
                            for (int i = 0; i < int'(len); i++) m_q.push_back(buf_mem[i]);
                            if (CRC_ON) begin
                                c = crc_of(m_q);
                                m_q.push_back(c[7:0]);
                                m_q.push_back(c[15:8]);
                            end
                            m_len = int'(len); m_idx = 0; m_addr = '0;
                            m_busy = 1; m_fetch = 2;
                        end
                    end
                end else if (m_sil > 0) begin
                    m_sil--;
                    if (m_sil == 0) begin
                        m_busy = 0;
                        m_quiet = 0;
                    end
                end else if (m_fetch > 0) begin
                    m_fetch--;
                    if (m_fetch == 0) m_dv = 1;
                end else if (m_dv != 0) begin
                    if (u_active) begin
                        m_dv = 0;
                        m_wait = 1;
                    end
                end else if (m_wait != 0 && u_done && !m_prev) begin
                    m_wait = 0;
                    m_idx++;
                    if (m_idx < m_len) m_addr = 8'(m_idx);
                    if (m_idx == m_q.size()) m_sil = SIL;
                    else m_fetch = 2;
                end
            end
            m_prev = u_done;
        end
    end

    task automatic pulse_start(input logic [7:0] l);
        @(posedge clk); #1;
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit poke);
        int n;
        n = 0;
        while (n < budget) begin
            if (busy !== 1'b1) break;
            start = poke && ($urandom_range(0, 29) == 0);
            if (start) len = 8'($urandom);
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0] exp1 [8];
        logic [7:0] pin[$];
        int base, d0, e0, h0, s1, n, l, tot;

        exp1 = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
        for (int i = 0; i < 256; i++) buf_mem[i] = 8'($urandom);

        // Reset values.
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_busy", busy, 1);
        chk("rst_dv", dv, 0);
        chk("rst_byte", txb, 0);
        chk("rst_addr", buf_addr, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_idle(SIL + 20, 1'b0);
        chk("post_rst_no_done", n_done, 0);

        // Reference frame 01 03 00 00 00 01.
        pin = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
        chk("model_crc", crc_of(pin), 16'h0A84);
        for (int i = 0; i < 6; i++) buf_mem[i] = exp1[i];
        base = rx_log.size();
        pulse_start(8'd6);
        wait_idle(2000, 1'b0);
        chk("f1_count", rx_log.size() - base, 6 + EXTRA);
        for (int i = 0; i < 6 + EXTRA; i++) chk("f1_byte", rx_log[base + i], exp1[i]);
        chk("f1_done_cnt", n_done, 1);
        chk("f1_done_lat", t_done - t_uedge, SIL);

        // Rejected length 0; length 255 depends on CRC.
        d0 = n_dv_cyc;
        pulse_start(8'd0);
        chk("err_len0", err_o, 1);
        chk("err_len0_busy", busy, 0);
        @(posedge clk); #1;
        chk("err_len0_clear", err_o, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("err_len0_no_dv", n_dv_cyc, d0);
        base = n_rx;
        pulse_start(8'd255);
        chk("len255_err", err_o, CRC_ON ? 1 : 0);
        wait_idle(256 * 50 + 400, 1'b0);
        chk("len255_count", n_rx - base, CRC_ON ? 0 : 255);

        // Starts while busy are ignored.
        for (int i = 0; i < 4; i++) buf_mem[i] = 8'($urandom);
        base = n_rx;
        e0 = n_err;
        pulse_start(8'd4);
        wait_idle(1000, 1'b1);
        chk("busy_start_count", n_rx - base, 4 + EXTRA);
        chk("busy_start_no_err", n_err, e0);

        // Single byte 0x5A.
        buf_mem[0] = 8'h5A;
        base = rx_log.size();
        d0 = n_dv_cyc;
        pulse_start(8'd1);
        wait_idle(1000, 1'b0);
        chk("one_dv_cycles", n_dv_cyc - d0, 2 * (1 + EXTRA));
        chk("one_count", rx_log.size() - base, 1 + EXTRA);
        chk("one_byte", rx_log[base], 8'h5A);

        // Reset during the third byte.
        for (int i = 0; i < 6; i++) buf_mem[i] = 8'($urandom);
        base = n_rx;
        h0 = n_handed;
        e0 = n_done;
        pulse_start(8'd6);
        n = 0;
        while (n_handed - h0 < 3 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid_rst_reach", n_handed - h0, 3);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_dv", dv, 0);
        chk("mid_rst_busy", busy, 1);
        wait_idle(SIL + 20, 1'b0);
        chk("mid_rst_handed", n_handed - h0, 3);
        chk("mid_rst_no_done", n_done, e0);
        chk("mid_rst_rx", n_rx - base, 3);

        // Back-to-back frames.
        for (int i = 0; i < 3; i++) buf_mem[i] = 8'($urandom);
        pulse_start(8'd3);
        wait_idle(1000, 1'b0);
        start = 1'b1;
        len = 8'd2;
        s1 = stop_cyc;
        h0 = n_handed;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_accept", busy, 1);
        n = 0;
        while (n_handed == h0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_started", n_handed > h0, 1);
        chk("b2b_gap", (start_cyc - s1) >= SIL, 1);
        wait_idle(1000, 1'b0);

        // Random frames with stray starts while busy.
        for (int f = 0; f < 8; f++) begin
            l = $urandom_range(1, 24);
            for (int i = 0; i < l; i++) buf_mem[i] = 8'($urandom);
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            base = n_rx;
            e0 = n_done;
            pulse_start(8'(l));
            tot = l + EXTRA;
            wait_idle(tot * 60 + 400, 1'b1);
            chk("rand_count", n_rx - base, tot);
            chk("rand_done", n_done - e0, 1);
        end

        repeat (10) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/modbus_tx_sequencer.md
# modbus_tx_sequencer

Frame-level transmit sequencer for the Modbus RTU controller. Reads a frame payload byte-by-byte from the TX frame buffer, feeds each byte to the byte-level `uart_tx` serializer through its `DV`/`Active`/`Done` handshake, and optionally appends the CRC-16/MODBUS. After each frame it enforces the RTU inter-frame silence (3.5 character times) before accepting the next frame.

## Interface
Parameters:
- `CLKS_PER_BIT`, 347 — must equal the value given to the attached `uart_tx`.
- `T35_BITS`, 39 — inter-frame silence in bit times.
  - Silence length `SILENCE_CLKS` = `T35_BITS*CLKS_PER_BIT`.
  - `SILENCE_CLKS` must be < 2^24.

Ports:
- `i_Clock` in 1 — system clock; single clock domain.
- `i_Reset` in 1 — reset, synchronous, active-high.
- `i_Start` in 1 — frame request; sampled only in IDLE.
- `i_Len` in 8 — payload byte count, sampled with `i_Start`.
- `o_Buf_Addr` out 8 — frame buffer read address.
- `i_Buf_Data` in 8 — buffer read data, valid exactly 1 cycle after `o_Buf_Addr` changes.
- `o_Tx_DV` out 1 — to `uart_tx` `i_Tx_DV`.
- `o_Tx_Byte` out 8 — to `uart_tx` `i_Tx_Byte`.
- `i_Tx_Active` in 1 — from `uart_tx` `o_Tx_Active`.
- `i_Tx_Done` in 1 — from `uart_tx` `o_Tx_Done`.
- `o_Busy` out 1 — high whenever the block is not in IDLE.
- `o_Done` out 1 — 1-cycle pulse at the end of a frame's silence.
- `o_Err` out 1 — 1-cycle pulse when a start request is rejected.

## Operation
- States: IDLE, FETCH, LOAD, SEND, WAIT, CRC_LO, CRC_HI, SILENCE.
- IDLE, `i_Start`=1:
  - If `i_Len`=0, or `i_Len`>254 with CRC enabled: pulse `o_Err` and stay in IDLE.
  - Otherwise: latch length; set `o_Buf_Addr`=0; CRC register=0xFFFF; go to FETCH.
- FETCH: one wait cycle for buffer read latency; go to LOAD.
- LOAD:
  - `o_Tx_Byte`<=`i_Buf_Data`.
  - Fold the byte into the CRC (CRC-16/MODBUS: reflected polynomial 0xA001, 8 bit-steps combinationally in one cycle).
  - `o_Tx_DV`<=1; go to SEND.
- SEND: hold `o_Tx_DV`=1 until `i_Tx_Active`=1 is sampled; then `o_Tx_DV`<=0 and go to WAIT.
- WAIT: wait for a rising edge of `i_Tx_Done` (current=1, registered previous=0). On the edge:
  - Bytes remain: `o_Buf_Addr`++, go to FETCH.
  - Payload done, CRC enabled: go to CRC_LO.
  - Payload done, CRC disabled: go to SILENCE.
- CRC_LO: `o_Tx_Byte`<=crc[7:0], `o_Tx_DV`<=1, go to SEND; WAIT then goes to CRC_HI.
- CRC_HI: `o_Tx_Byte`<=crc[15:8], `o_Tx_DV`<=1, go to SEND; WAIT then goes to SILENCE.
- Byte order on the wire is low CRC byte first.
- SILENCE: count `SILENCE_CLKS` cycles.
  - At the end: pulse `o_Done` (suppressed after the post-reset silence) and go to IDLE.
- `i_Start` outside IDLE is ignored; no `o_Err` is raised and nothing is queued.
- `i_Tx_Done` held high for 2 cycles counts as one edge only.

## Timing
- Reset values: state=SILENCE (post-reset silence), silence counter=0.
  - Outputs: `o_Busy`=1, `o_Tx_DV`=0, `o_Tx_Byte`=0, `o_Buf_Addr`=0, `o_Done`=0, `o_Err`=0.
- `i_Start` sampled at edge N: FETCH at N+1, LOAD at N+2, `o_Tx_DV` high from N+3.
- `o_Err` is high in cycle N+1 for a rejected request.
- `o_Tx_DV` stays high until the cycle after `i_Tx_Active` is first sampled high (normally 2 cycles total).
- Next byte's `o_Tx_DV` rises 3 cycles after the `i_Tx_Done` rising edge is sampled. `uart_tx` is already back in IDLE by then.
- `o_Tx_Byte` is stable from DV assertion until the next LOAD/CRC state.
- `o_Done` is asserted in the last SILENCE cycle; IDLE follows on the next edge, and `o_Busy` drops in that same cycle.
- Reset mid-frame:
  - The sequencer drops `o_Tx_DV` at once and restarts the silence count.
  - `uart_tx` has no reset and finishes its byte in flight; the restarted silence covers that byte.
  - A `i_Tx_Done` edge seen during SILENCE is ignored.

## Configuration
- `MODBUS_TX_CRC_EN` defined:
  - CRC register and CRC_LO/CRC_HI states are present.
  - Frames carry `i_Len`+2 bytes on the wire.
  - `i_Len` range is 1..254.
- `MODBUS_TX_CRC_EN` undefined:
  - No CRC logic; WAIT after the last payload byte goes directly to SILENCE.
  - Frames carry exactly `i_Len` bytes.
  - `i_Len` range is 1..255.

## Test plan
Bench pairs this block with `uart_tx` at `CLKS_PER_BIT`=4, `T35_BITS`=39, and decodes the serial line.
- CRC on; buffer 01 03 00 00 00 01; `i_Len`=6; start → serial bytes 01 03 00 00 00 01 84 0A; `o_Done` one pulse 156 cycles after the last byte's Done edge.
- CRC on; `i_Len`=0 → `o_Err` pulse in cycle N+1, no `o_Tx_DV`, `o_Busy` stays 0. Same result for `i_Len`=255.
- `i_Start` pulsed while `o_Busy`=1 → ignored; byte count on the line is unchanged; no `o_Err`.
- `i_Len`=1, buffer 0x5A, CRC off → exactly one byte 0x5A; `o_Tx_DV` high for exactly 2 cycles; `o_Busy` high until `o_Done`.
- Reset asserted during the 3rd byte → `o_Tx_DV`=0 the next cycle; 3rd byte completes; no further bytes; `o_Busy`=1 for 156 cycles; then IDLE with no `o_Done` pulse.
- Back-to-back frames: start asserted in the cycle `o_Busy` falls → accepted; gap between the stop bit of frame 1 and the start bit of frame 2 is ≥156 cycles.
